// File: rtl/dvsd_div_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package dvsd_div_pkg;

    localparam int WN_DEF = 16;
    localparam int WD_DEF = 8;
    localparam int CNT_W  = $clog2(WN_DEF);

    localparam logic [WN_DEF-1:0] DZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/dvsd_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// compare against the divisor and conditionally subtract.
module dvsd_div_step #(
    parameter int WD = 8
) (
    input  logic [WD:0]   rem,
    input  logic          q_msb,
    input  logic [WD-1:0] d,
    output logic [WD:0]   rem_next,
    output logic          q_bit
);

    logic [WD:0] shifted;
    logic        fits;
    logic        unused_rem_msb;

    // The top bit of the partial remainder is always clear after a restore,
    // so it is shifted out and never reaches the comparison.
    assign unused_rem_msb = rem[WD];

    always_comb begin
        shifted  = {rem[WD-1:0], q_msb};
        fits     = (shifted >= {1'b0, d});
        rem_next = fits ? (shifted - {1'b0, d}) : shifted;
        q_bit    = fits;
    end

endmodule

// File: rtl/dvsd_div16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero shortcut.
module dvsd_div16by8
    import dvsd_div_pkg::*;
#(
    parameter int WN = WN_DEF,
    parameter int WD = WD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WN-1:0] N,
    input  logic [WD-1:0] D,
    output logic          busy,
    output logic          done,
    output logic [WN-1:0] Q,
    output logic [WD-1:0] R,
    output logic          dz
);

    div_state_t       state;
    div_state_t       state_next;

    logic [WN-1:0]    q_work;
    logic [WD-1:0]    d_reg;
    logic [WD:0]      rem;
    logic [CNT_W-1:0] cnt;

    logic [WD:0]      rem_next;
    logic             q_bit;
    logic [WN-1:0]    q_shifted;

    dvsd_div_step #(.WD(WD)) u_step (
        .rem      (rem),
        .q_msb    (q_work[WN-1]),
        .d        (d_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_shifted = {q_work[WN-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (D == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working registers are separate from Q/R/dz so results hold while
    // the next division runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_work <= '0;
            d_reg  <= '0;
            rem    <= '0;
            cnt    <= '0;
            Q      <= '0;
            R      <= '0;
            dz     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (D != '0) begin
                            q_work <= N;
                            d_reg  <= D;
                            rem    <= '0;
                            cnt    <= CNT_W'(WN - 1);
                        end else begin
                            Q  <= DZ_QUOT;
                            R  <= N[WD-1:0];
                            dz <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem    <= rem_next;
                    q_work <= q_shifted;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        Q  <= q_shifted;
                        R  <= rem_next[WD-1:0];
                        dz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
